// File: rtl/wb_grf.sv
// wb_grf: MIPS write-back stage plus the 32x32 general register file.
// Decodes the W-stage destination and write data (including load byte/half
// extraction), writes the register file on the clock edge, and serves the
// two D-stage read ports with an optional write-first bypass.
module wb_grf #(
  parameter bit BYPASS = 1'b1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] IR_W,
  input  logic [31:0] PC4_W,
  input  logic [31:0] AO_W,
  input  logic [31:0] DR_W,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  output logic [31:0] RD1,
  output logic [31:0] RD2,
  output logic [4:0]  A3_W,
  output logic [31:0] WD_W,
  output logic        WE_W
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_LHU   = 6'b100101;

  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_JALR  = 6'b001001;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MTLO  = 6'b010011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rtField;
  logic [4:0]  rdField;
  logic [31:0] linkData;
  logic [7:0]  loadByte;
  logic [15:0] loadHalf;
  logic [31:0] loadData;
  logic        destValid;
  logic [4:0]  destReg;
  logic [31:0] destData;

  logic [31:0] regFile_q [32];

  assign opcode   = IR_W[31:26];
  assign funct    = IR_W[5:0];
  assign rtField  = IR_W[20:16];
  assign rdField  = IR_W[15:11];
  assign linkData = PC4_W + 32'd4;

  // Select the addressed byte/half of the raw memory word and extend it per load type.
  always_comb begin
    loadByte = DR_W[7:0];
    case (AO_W[1:0])
      2'd0: loadByte = DR_W[7:0];
      2'd1: loadByte = DR_W[15:8];
      2'd2: loadByte = DR_W[23:16];
      2'd3: loadByte = DR_W[31:24];
      default: loadByte = DR_W[7:0];
    endcase
    loadHalf = AO_W[1] ? DR_W[31:16] : DR_W[15:0];
    case (opcode)
      OP_LB:   loadData = {{24{loadByte[7]}}, loadByte};
      OP_LBU:  loadData = {24'd0, loadByte};
      OP_LH:   loadData = {{16{loadHalf[15]}}, loadHalf};
      OP_LHU:  loadData = {16'd0, loadHalf};
      default: loadData = DR_W;
    endcase
  end

  // Decode which register (if any) this instruction writes and with what data.
  always_comb begin
    destValid = 1'b0;
    destReg   = 5'd0;
    destData  = AO_W;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_JR, FN_MULT, FN_MULTU, FN_DIV, FN_DIVU, FN_MTHI, FN_MTLO: begin
            destValid = 1'b0;
          end
          FN_JALR: begin
            destValid = 1'b1;
            destReg   = rdField;
            destData  = linkData;
          end
          default: begin
            destValid = 1'b1;
            destReg   = rdField;
            destData  = AO_W;
          end
        endcase
      end
      6'b001000, 6'b001001, 6'b001010, 6'b001011,
      6'b001100, 6'b001101, 6'b001110, 6'b001111: begin
        destValid = 1'b1;
        destReg   = rtField;
        destData  = AO_W;
      end
      OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW: begin
        destValid = 1'b1;
        destReg   = rtField;
        destData  = loadData;
      end
      OP_JAL: begin
        destValid = 1'b1;
        destReg   = 5'd31;
        destData  = linkData;
      end
      default: begin
        destValid = 1'b0;
      end
    endcase
  end

  assign A3_W = destValid ? destReg : 5'd0;
  assign WD_W = destData;
  assign WE_W = destValid && (destReg != 5'd0);

  // Register file storage: reset clears everything and blocks that cycle's write.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 32; i++) begin
        regFile_q[i] <= 32'd0;
      end
    end else if (WE_W) begin
      regFile_q[A3_W] <= WD_W;
    end
  end

  // Read ports: $0 is hard zero, then the optional same-cycle bypass, then storage.
  always_comb begin
    if (A1 == 5'd0) begin
      RD1 = 32'd0;
    end else if (BYPASS && WE_W && (A3_W == A1)) begin
      RD1 = WD_W;
    end else begin
      RD1 = regFile_q[A1];
    end
    if (A2 == 5'd0) begin
      RD2 = 32'd0;
    end else if (BYPASS && WE_W && (A3_W == A2)) begin
      RD2 = WD_W;
    end else begin
      RD2 = regFile_q[A2];
    end
  end

endmodule
